// File: rtl/servo_ramp_ctrl.sv
// rtl/servo_ramp_ctrl.sv - servo PWM generator with clamped, slew-limited width commands
module servo_ramp_ctrl #(
  parameter int W           = 10,
  parameter int FRAME_TICKS = 1000,
  parameter int MIN_PULSE   = 50,
  parameter int MAX_PULSE   = 100,
  parameter int CENTER      = 75,
  parameter int STEP        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_in,
  input  logic         en,
  input  logic         cmd_valid,
  input  logic [W-1:0] cmd_pos,
  output logic         cmd_ready,
  output logic         pwm_out,
  output logic [W-1:0] duty,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [W-1:0] MIN_W      = W'(MIN_PULSE);
  localparam logic [W-1:0] MAX_W      = W'(MAX_PULSE);
  localparam logic [W-1:0] CENTER_W   = W'(CENTER);
  localparam logic [W-1:0] STEP_W     = W'(STEP);
  localparam logic [W-1:0] FRAME_LAST = W'(FRAME_TICKS - 1);
  localparam logic [W-1:0] ONE_W      = W'(1);

  state_t         state, state_nx;
  logic           tick_d;
  logic [W-1:0]   frame_cnt;
  logic [W-1:0]   cur_width, cur_width_nx;
  logic [W-1:0]   target, target_nx;
  logic           done_nx;
  logic           tick_rise;
  logic           boundary;
  logic [W-1:0]   tgt_c;
  logic [W-1:0]   ramp_width;

  assign tick_rise = tick_in & ~tick_d;
  assign boundary  = en & tick_rise & (frame_cnt == FRAME_LAST);
  assign duty      = cur_width;

  always_comb begin
    tgt_c = cmd_pos;
    if (cmd_pos < MIN_W)
      tgt_c = MIN_W;
    else if (cmd_pos > MAX_W)
      tgt_c = MAX_W;
  end

  // One slew step toward target, landing exactly on it when closer than STEP.
  always_comb begin
    ramp_width = target;
    if (target > cur_width) begin
      if ((target - cur_width) > STEP_W)
        ramp_width = cur_width + STEP_W;
    end else if (cur_width > target) begin
      if ((cur_width - target) > STEP_W)
        ramp_width = cur_width - STEP_W;
    end
  end

  always_comb begin
    state_nx     = state;
    cur_width_nx = cur_width;
    target_nx    = target;
    done_nx      = 1'b0;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          target_nx = tgt_c;
          if (tgt_c == cur_width)
            done_nx = 1'b1;
          else
            state_nx = RAMP;
        end
      end
      RAMP: begin
        busy = 1'b1;
        if (boundary) begin
          cur_width_nx = ramp_width;
          if (ramp_width == target) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tick_d    <= 1'b0;
      frame_cnt <= '0;
      cur_width <= CENTER_W;
      target    <= CENTER_W;
      pwm_out   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_d    <= tick_in;
      cur_width <= cur_width_nx;
      target    <= target_nx;
      done      <= done_nx;
      pwm_out   <= en & (frame_cnt < cur_width);
      if (!en)
        frame_cnt <= '0;
      else if (tick_rise)
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + ONE_W;
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb/tb_servo_ramp_ctrl.sv - directed self-checking bench for servo_ramp_ctrl
module tb_servo_ramp_ctrl;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick_in = 1'b0;
  logic         en = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [W-1:0] cmd_pos = '0;
  logic         cmd_ready;
  logic         pwm_out;
  logic [W-1:0] duty;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_double = 0;
  logic done_prev = 1'b0;
  int tc = 0;

  servo_ramp_ctrl #(
    .W(W), .FRAME_TICKS(20), .MIN_PULSE(2), .MAX_PULSE(10), .CENTER(6), .STEP(2)
  ) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .en(en),
    .cmd_valid(cmd_valid), .cmd_pos(cmd_pos), .cmd_ready(cmd_ready),
    .pwm_out(pwm_out), .duty(duty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // tick_in: period 4 clk, high 2 / low 2
  initial begin
    forever begin
      @(negedge clk);
      tc = tc + 1;
      tick_in = ((tc % 4) < 2);
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (done === 1'b1 && done_prev === 1'b1) done_double = done_double + 1;
    done_prev = done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int pos);
    cmd_pos = W'(pos);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Skip the pulse in progress and stop at the negedge where the next pulse is first seen.
  task automatic sync_rise(input string tag);
    int n = 0;
    while (pwm_out === 1'b1 && n < 400) begin @(negedge clk); n++; end
    while (pwm_out !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  // Starting at a pulse start: high clocks, frame period in clocks, width in use.
  task automatic measure(output int hi, output int per, output logic [W-1:0] d);
    d = duty;
    hi = 0;
    per = 0;
    while (pwm_out === 1'b1 && per < 400) begin @(negedge clk); hi++; per++; end
    while (pwm_out !== 1'b1 && per < 400) begin @(negedge clk); per++; end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 2000), 32'd1);
  endtask

  int hi, per;
  logic [W-1:0] d;

  initial begin
    // T1 reset and centre pulse
    step(1);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_duty", 32'(duty), 32'd6);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step(2);
    rst = 1'b1;
    en = 1'b1;
    sync_rise("t1_sync_a");
    sync_rise("t1_sync_b");
    measure(hi, per, d);
    chk("t1_high", hi, 24);
    chk("t1_period", per, 80);
    chk("t1_duty", 32'(d), 32'd6);

    // T2 ramp up 6 -> 8 -> 10
    send(10);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_ready", 32'(cmd_ready), 32'd0);
    chk("t2_duty0", 32'(duty), 32'd6);
    sync_rise("t2_sync");
    measure(hi, per, d);
    chk("t2_duty8", 32'(d), 32'd8);
    chk("t2_high8", hi, 32);
    measure(hi, per, d);
    chk("t2_duty10", 32'(d), 32'd10);
    chk("t2_high10", hi, 40);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_ready_again", 32'(cmd_ready), 32'd1);
    chk("t2_done_cnt", done_cnt, 1);

    // T3 clamp high (equal to current) and clamp low
    send(15);
    chk("t3_clamp_hi_done", 32'(done), 32'd1);
    chk("t3_clamp_hi_busy", 32'(busy), 32'd0);
    chk("t3_clamp_hi_duty", 32'(duty), 32'd10);
    send(0);
    chk("t3_down_busy", 32'(busy), 32'd1);
    sync_rise("t3_sync");
    for (int i = 0; i < 4; i++) begin
      measure(hi, per, d);
      chk("t3_down_duty", 32'(d), 32'(8 - 2 * i));
      chk("t3_down_high", hi, 4 * (8 - 2 * i));
    end
    chk("t3_down_idle", 32'(busy), 32'd0);

    // T4 partial final step and equal command
    send(6);
    wait_idle("t4_wait_6");
    chk("t4_duty6", 32'(duty), 32'd6);
    send(7);
    chk("t4_busy7", 32'(busy), 32'd1);
    sync_rise("t4_sync");
    measure(hi, per, d);
    chk("t4_duty7", 32'(d), 32'd7);
    chk("t4_high7", hi, 28);
    chk("t4_idle7", 32'(busy), 32'd0);
    send(7);
    chk("t4_eq_done", 32'(done), 32'd1);
    chk("t4_eq_busy", 32'(busy), 32'd0);
    chk("t4_eq_ready", 32'(cmd_ready), 32'd1);

    // T5 enable dropped mid-ramp 7 -> 9 -> 10
    send(10);
    chk("t5_busy", 32'(busy), 32'd1);
    sync_rise("t5_sync");
    chk("t5_duty9", 32'(duty), 32'd9);
    step(3);
    en = 1'b0;
    @(negedge clk);
    chk("t5_off_pwm", 32'(pwm_out), 32'd0);
    chk("t5_off_busy", 32'(busy), 32'd1);
    step(50);
    chk("t5_hold_duty", 32'(duty), 32'd9);
    chk("t5_hold_pwm", 32'(pwm_out), 32'd0);
    chk("t5_hold_busy", 32'(busy), 32'd1);
    en = 1'b1;
    @(negedge clk);
    chk("t5_restart_pwm", 32'(pwm_out), 32'd1);
    sync_rise("t5_sync2");
    measure(hi, per, d);
    chk("t5_duty10", 32'(d), 32'd10);
    chk("t5_high10", hi, 40);
    chk("t5_idle", 32'(busy), 32'd0);

    // T6 commands ignored during RAMP, then reset mid-ramp
    send(2);
    cmd_pos = W'(3);
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_not_ready", 32'(cmd_ready), 32'd0);
    wait_done("t6_wait_done");
    chk("t6_end_duty", 32'(duty), 32'd2);
    chk("t6_end_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_accept_busy", 32'(busy), 32'd1);
    step(5);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_duty", 32'(duty), 32'd6);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
    chk("t6_rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    step(200);
    chk("t6_post_busy", 32'(busy), 32'd0);
    chk("t6_post_duty", 32'(duty), 32'd6);

    chk("done_total", done_cnt, 8);
    chk("done_single", done_double, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
